rv32i_dmem_arbiter: RTL

Two-port arbiter that shares the single-ported 32-word data memory between the pipeline MEM stage (core port) and an external host/debug port used for preloading and inspecting data. It sits between the MEM stage and the DMEM array. It grants at most one access per cycle, round-robin when both ports request. The host can also lock the memory for a bounded burst. Read data returns one cycle after the grant to the port that issued the read.

---
 rtl/rv32i_pkg.sv | 24 ++
 rtl/rv32i_dmem_rdret.sv | 68 ++++++
 rtl/rv32i_dmem_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg
// Shared definitions for the RV32I data-memory arbiter slice:
//   - DMEM word-address and data width constants, and the default host lock length
//   - arb_state_t : arbiter priority/lock state
//   - rd_tag_t    : which port owns the read data returning next cycle
package rv32i_pkg;

  localparam int DMEM_ADDR_W   = 5;
  localparam int DMEM_DATA_W   = 32;
  localparam int DMEM_LOCK_MAX = 16;

  typedef enum logic [1:0] {
    PRI_CORE = 2'd0,
    PRI_HOST = 2'd1,
    LOCKED   = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    RT_NONE = 2'd0,
    RT_CORE = 2'd1,
    RT_HOST = 2'd2
  } rd_tag_t;

endpackage

// File: rtl/rv32i_dmem_rdret.sv
// rv32i_dmem_rdret
// Read-return steering for the DMEM arbiter. The owner of a read granted in
// the current cycle is recorded, and in the following cycle that port sees
// rvalid=1 with the live memory read data. Each port's rdata otherwise holds
// the last value it was handed.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   c_rd, h_rd           core / host read granted this cycle
//   m_rdata              memory read data (valid the cycle after a read grant)
//   c_rvalid, c_rdata    core read return
//   h_rvalid, h_rdata    host read return
module rv32i_dmem_rdret
  import rv32i_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_rd,
  input  logic              h_rd,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata
);

  rd_tag_t           tag_r;
  rd_tag_t           tag_next_s;
  logic [DATA_W-1:0] c_hold_r;
  logic [DATA_W-1:0] h_hold_r;

  // Decide which port owns the read data arriving next cycle.
  always_comb begin
    tag_next_s = RT_NONE;
    if (c_rd) begin
      tag_next_s = RT_CORE;
    end else if (h_rd) begin
      tag_next_s = RT_HOST;
    end else begin
      tag_next_s = RT_NONE;
    end
  end

  // Return tag and per-port held read data; reset drops any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_r    <= RT_NONE;
      c_hold_r <= {DATA_W{1'b0}};
      h_hold_r <= {DATA_W{1'b0}};
    end else begin
      tag_r <= tag_next_s;
      if (tag_r == RT_CORE) begin
        c_hold_r <= m_rdata;
      end
      if (tag_r == RT_HOST) begin
        h_hold_r <= m_rdata;
      end
    end
  end

  // The tagged port sees the memory output directly, so latency stays at one cycle.
  assign c_rvalid = (tag_r == RT_CORE);
  assign h_rvalid = (tag_r == RT_HOST);
  assign c_rdata  = c_rvalid ? m_rdata : c_hold_r;
  assign h_rdata  = h_rvalid ? m_rdata : h_hold_r;

endmodule

// File: rtl/rv32i_dmem_arbiter.sv
// rv32i_dmem_arbiter
// Shares the single-ported 32-word DMEM between the pipeline MEM stage (core
// port) and a host/debug port. At most one access is granted per cycle,
// round-robin on conflict. The host may lock the memory for up to LOCK_MAX
// consecutive grants, after which a waiting core is served first.
// Optional build macro: DMEM_ARB_STATS_EN adds saturating 16-bit counters
// stat_conflicts (cycles with both requesting) and stat_core_wait (cycles the
// core requested without a grant).
// Ports:
//   clk, RN                         clock, asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata       core request
//   c_gnt, c_rvalid, c_rdata        core grant (combinational) and read return
//   h_req/h_we/h_lock/h_addr/h_wdata host request with lock hold
//   h_gnt, h_rvalid, h_rdata        host grant (combinational) and read return
//   m_en/m_we/m_addr/m_wdata        memory access, issued in the grant cycle
//   m_rdata                         memory read data, one cycle after a read
module rv32i_dmem_arbiter
  import rv32i_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int LOCK_MAX = DMEM_LOCK_MAX
) (
  input  logic              clk,
  input  logic              RN,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              h_req,
  input  logic              h_we,
  input  logic              h_lock,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]       stat_conflicts,
  output logic [15:0]       stat_core_wait,
`endif
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int                CNT_W     = $clog2(LOCK_MAX + 1);
  // A grant taken with the counter at this value is the LOCK_MAX-th of the burst.
  localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_MAX - 1);

  arb_state_t       state_r;
  arb_state_t       state_next_s;
  logic [CNT_W-1:0] lock_cnt_r;
  logic [CNT_W-1:0] lock_cnt_next_s;
  logic             c_win_s;
  logic             h_win_s;

  // Pick the winner for this cycle from the current priority/lock state.
  always_comb begin
    c_win_s = 1'b0;
    h_win_s = 1'b0;
    case (state_r)
      PRI_CORE: begin
        c_win_s = c_req;
        h_win_s = h_req & ~c_req;
      end
      PRI_HOST: begin
        h_win_s = h_req;
        c_win_s = c_req & ~h_req;
      end
      LOCKED: begin
        h_win_s = h_req;
        c_win_s = 1'b0;
      end
      default: begin
        c_win_s = 1'b0;
        h_win_s = 1'b0;
      end
    endcase
  end

  // Grants are suppressed while reset is held.
  assign c_gnt = c_win_s & RN;
  assign h_gnt = h_win_s & RN;

  // Round-robin hand-off after each grant; host lock bursts are bounded.
  always_comb begin
    state_next_s    = state_r;
    lock_cnt_next_s = lock_cnt_r;
    case (state_r)
      PRI_CORE, PRI_HOST: begin
        if (h_win_s) begin
          if (h_lock && (LOCK_MAX > 1)) begin
            state_next_s    = LOCKED;
            lock_cnt_next_s = CNT_W'(1);
          end else begin
            state_next_s    = PRI_CORE;
            lock_cnt_next_s = {CNT_W{1'b0}};
          end
        end else if (c_win_s) begin
          state_next_s = PRI_HOST;
        end else begin
          state_next_s = state_r;
        end
      end
      LOCKED: begin
        if (!h_req || !h_lock || (lock_cnt_r >= LOCK_LAST)) begin
          state_next_s    = PRI_CORE;
          lock_cnt_next_s = {CNT_W{1'b0}};
        end else begin
          state_next_s    = LOCKED;
          lock_cnt_next_s = lock_cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_next_s    = PRI_CORE;
        lock_cnt_next_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // Arbiter state and lock counter.
  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      state_r    <= PRI_CORE;
      lock_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_next_s;
      lock_cnt_r <= lock_cnt_next_s;
    end
  end

  // Memory command mux; idle cycles drive zeros.
  always_comb begin
    m_en    = c_gnt | h_gnt;
    m_we    = 1'b0;
    m_addr  = {ADDR_W{1'b0}};
    m_wdata = {DATA_W{1'b0}};
    if (c_gnt) begin
      m_we    = c_we;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end else if (h_gnt) begin
      m_we    = h_we;
      m_addr  = h_addr;
      m_wdata = h_wdata;
    end else begin
      m_we    = 1'b0;
    end
  end

  rv32i_dmem_rdret #(
    .DATA_W (DATA_W)
  ) u_rdret (
    .clk      (clk),
    .rst_n    (RN),
    .c_rd     (c_gnt & ~c_we),
    .h_rd     (h_gnt & ~h_we),
    .m_rdata  (m_rdata),
    .c_rvalid (c_rvalid),
    .c_rdata  (c_rdata),
    .h_rvalid (h_rvalid),
    .h_rdata  (h_rdata)
  );

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflicts_r;
  logic [15:0] core_wait_r;

  // Saturating contention statistics.
  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      conflicts_r <= 16'd0;
      core_wait_r <= 16'd0;
    end else begin
      if (c_req && h_req && (conflicts_r != 16'hFFFF)) begin
        conflicts_r <= conflicts_r + 16'd1;
      end
      if (c_req && !c_gnt && (core_wait_r != 16'hFFFF)) begin
        core_wait_r <= core_wait_r + 16'd1;
      end
    end
  end

  assign stat_conflicts = conflicts_r;
  assign stat_core_wait = core_wait_r;
`endif

endmodule
